pad_poller: RTL and testbench

Parametrised serial game-pad poller for NES (8-bit) and SNES (16-bit) controllers, covering one or more pads that share one latch/clock pair. It generates the latch and clock waveforms and samples every pad's data line in parallel. It delivers a debounced-by-frame button snapshot plus per-frame pressed/released edge vectors, on manual request or on a free-running auto-poll period. It sits between the pad connector pins and game logic, in place of the single-pad 8-bit reader.

---
 rtl/pad_pkg.sv | 38 +++
 rtl/pad_phase_timer.sv | 45 ++++
 rtl/pad_poller.sv | 187 ++++++++++++++++++
 tb/tb_pad_poller.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared definitions for the serial game-pad poller: FSM encoding and
// button bit positions within a pad's slice (first serial bit at the MSB).
package pad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LATCH = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int unsigned NES_BITS  = 8;
    localparam int unsigned SNES_BITS = 16;

    localparam int unsigned NES_A      = 7;
    localparam int unsigned NES_B      = 6;
    localparam int unsigned NES_SELECT = 5;
    localparam int unsigned NES_START  = 4;
    localparam int unsigned NES_UP     = 3;
    localparam int unsigned NES_DOWN   = 2;
    localparam int unsigned NES_LEFT   = 1;
    localparam int unsigned NES_RIGHT  = 0;

    // SNES serial order B,Y,SEL,STA,U,D,L,R,A,X,L,R; bits 3..0 carry no buttons
    localparam int unsigned SNES_B      = 15;
    localparam int unsigned SNES_Y      = 14;
    localparam int unsigned SNES_SELECT = 13;
    localparam int unsigned SNES_START  = 12;
    localparam int unsigned SNES_UP     = 11;
    localparam int unsigned SNES_DOWN   = 10;
    localparam int unsigned SNES_LEFT   = 9;
    localparam int unsigned SNES_RIGHT  = 8;
    localparam int unsigned SNES_A      = 7;
    localparam int unsigned SNES_X      = 6;
    localparam int unsigned SNES_L      = 5;
    localparam int unsigned SNES_R      = 4;

endpackage

// File: rtl/pad_phase_timer.sv
// Per-bit phase counter (0..2*CPP-1) with strobes at the half point,
// the mid-phase sample point and the terminal count.
module pad_phase_timer #(
    parameter int unsigned CYCLES_PER_PULSE = 150
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_half,
    output logic o_sample,
    output logic o_terminal
);

    localparam int unsigned PERIOD = 2 * CYCLES_PER_PULSE;
    localparam int unsigned CW     = $clog2(PERIOD);

    localparam logic [CW-1:0] HALF_AT   = CW'(CYCLES_PER_PULSE - 1);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(CYCLES_PER_PULSE + CYCLES_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] LAST_AT   = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_half     = i_run && (cnt_q == HALF_AT);
    assign o_sample   = i_run && (cnt_q == SAMPLE_AT);
    assign o_terminal = i_run && (cnt_q == LAST_AT);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_run) begin
            cnt_d = o_terminal ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pad_poller.sv
// Multi-pad NES/SNES poller: drives shared latch/clock, samples every pad's
// data line in parallel and publishes per-frame snapshot and edge vectors.
module pad_poller
    import pad_pkg::*;
#(
    parameter int unsigned CYCLES_PER_PULSE = 150,
    parameter int unsigned NUM_PADS         = 2,
    parameter int unsigned NUM_BITS         = 8,
    parameter int unsigned POLL_PERIOD      = 0
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    input  logic                         i_read_buttons,
    output logic                         o_busy,
    output logic                         o_valid,
    output logic [NUM_PADS*NUM_BITS-1:0] o_buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] o_pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] o_released,
    input  logic [NUM_PADS-1:0]          i_controller_data,
    output logic                         o_controller_latch,
    output logic                         o_controller_clock
);

    localparam int unsigned W  = NUM_PADS * NUM_BITS;
    localparam int unsigned BW = $clog2(NUM_BITS);
    localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);

    if (CYCLES_PER_PULSE < 2) begin : g_bad_cpp
        $error("pad_poller: CYCLES_PER_PULSE must be >= 2");
    end
    if (NUM_PADS < 1) begin : g_bad_pads
        $error("pad_poller: NUM_PADS must be >= 1");
    end
    if (NUM_BITS < 2 || NUM_BITS > 32) begin : g_bad_bits
        $error("pad_poller: NUM_BITS must be in 2..32");
    end
    if (POLL_PERIOD != 0 && POLL_PERIOD < NUM_BITS * 2 * CYCLES_PER_PULSE + 2) begin : g_bad_period
        $error("pad_poller: POLL_PERIOD shorter than one frame");
    end

    state_t        state_q, state_d;
    logic          latch_q, latch_d;
    logic          clock_q, clock_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [W-1:0]  sr_q, sr_d, sr_next;
    logic [W-1:0]  buttons_q, buttons_d;
    logic [W-1:0]  pressed_q, pressed_d;
    logic [W-1:0]  released_q, released_d;

    logic poll_tick, start, run;
    logic ph_half, ph_sample, ph_terminal;

    assign run = (state_q == ST_LATCH) || (state_q == ST_SHIFT);

    pad_phase_timer #(
        .CYCLES_PER_PULSE(CYCLES_PER_PULSE)
    ) u_timer (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (start),
        .i_run      (run),
        .o_half     (ph_half),
        .o_sample   (ph_sample),
        .o_terminal (ph_terminal)
    );

    always_comb begin
        poll_tick = 1'b0;
        if (POLL_PERIOD > 0) begin
            poll_tick = (poll_q == POLL_LAST);
        end
    end

    assign start = (state_q == ST_IDLE) && (i_read_buttons || poll_tick);

    // Any frame start restarts the auto-poll period, manual ones included.
    always_comb begin
        poll_d = '0;
        if (POLL_PERIOD > 0) begin
            poll_d = (start || poll_tick) ? '0 : poll_q + 1'b1;
        end
    end

    always_comb begin
        sr_next = sr_q;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            sr_next[p*NUM_BITS +: NUM_BITS] = {sr_q[p*NUM_BITS +: NUM_BITS-1], ~i_controller_data[p]};
        end
    end

    // buttons_q doubles as the previous-frame register for the edge vectors.
    always_comb begin
        state_d    = state_q;
        latch_d    = latch_q;
        clock_d    = clock_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        bit_d      = bit_q;
        sr_d       = sr_q;
        buttons_d  = buttons_q;
        pressed_d  = pressed_q;
        released_d = released_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch_d = 1'b1;
                    busy_d  = 1'b1;
                    sr_d    = '0;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (ph_half)   latch_d = 1'b0;
                if (ph_sample) sr_d = sr_next;
                if (ph_terminal) begin
                    clock_d = 1'b0;
                    bit_d   = BW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ph_half)   clock_d = 1'b1;
                if (ph_sample) sr_d = sr_next;
                if (ph_terminal) begin
                    if (bit_q == LAST_BIT) begin
                        state_d    = ST_DONE;
                        valid_d    = 1'b1;
                        buttons_d  = sr_q;
                        pressed_d  = sr_q & ~buttons_q;
                        released_d = ~sr_q & buttons_q;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        clock_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            latch_q    <= 1'b0;
            clock_q    <= 1'b1;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bit_q      <= '0;
            poll_q     <= '0;
            sr_q       <= '0;
            buttons_q  <= '0;
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            state_q    <= state_d;
            latch_q    <= latch_d;
            clock_q    <= clock_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            bit_q      <= bit_d;
            poll_q     <= poll_d;
            sr_q       <= sr_d;
            buttons_q  <= buttons_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign o_busy             = busy_q;
    assign o_valid            = valid_q;
    assign o_buttons          = buttons_q;
    assign o_pressed          = pressed_q;
    assign o_released         = released_q;
    assign o_controller_latch = latch_q;
    assign o_controller_clock = clock_q;

endmodule

// File: tb/tb_pad_poller.sv
// Bench for pad_poller: three instances (manual 8-bit, auto-poll 8-bit,
// manual 16-bit) driven by behavioural pads that react to latch/clock pins.
module tb_pad_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    // ---------------- instance A: CPP=4, 2 pads, 8 bits, manual ----------------
    logic        rst_a = 1'b0, req_a = 1'b0;
    logic        busy_a, valid_a, latch_a, clock_a;
    logic [15:0] btn_a, prs_a, rel_a;
    logic [1:0]  data_a;

    pad_poller #(.CYCLES_PER_PULSE(4), .NUM_PADS(2), .NUM_BITS(8), .POLL_PERIOD(0)) u_a (
        .clk(clk), .i_rst_n(rst_a), .i_read_buttons(req_a), .o_busy(busy_a), .o_valid(valid_a),
        .o_buttons(btn_a), .o_pressed(prs_a), .o_released(rel_a), .i_controller_data(data_a),
        .o_controller_latch(latch_a), .o_controller_clock(clock_a));

    // Pad behaviour: latch loads the pattern and presents bit 0; each rising
    // pad clock presents the next bit. Pattern MSB is the first serial bit.
    logic [7:0]  pat_a [2];
    logic [7:0]  held_a [2];
    int unsigned idx_a = 8;
    logic        lprev_a = 1'b0, cprev_a = 1'b1;
    always @(negedge clk) begin
        if (latch_a && !lprev_a) begin
            idx_a = 0;
            held_a = pat_a;
        end else if (clock_a && !cprev_a && !latch_a) begin
            idx_a++;
        end
        lprev_a = latch_a;
        cprev_a = clock_a;
        for (int p = 0; p < 2; p++)
            data_a[p] = (idx_a < 8) ? ~held_a[p][3'(7 - idx_a)] : 1'b1;
    end

    // Waveform monitor for A (cumulative; sequences diff against snapshots).
    int unsigned mon_latch = 0, mon_busy = 0, mon_valid = 0, mon_idlebad = 0;
    int unsigned mon_runs = 0, mon_badrun = 0, mon_btnchg = 0, ck_run = 0;
    logic [15:0] btn_prev_a = '0;
    always @(negedge clk) begin
        if (latch_a) mon_latch++;
        if (busy_a)  mon_busy++;
        if (valid_a) mon_valid++;
        if (!clock_a && (!busy_a || latch_a)) mon_idlebad++;
        if (!clock_a) begin
            ck_run++;
        end else begin
            if (ck_run != 0) begin
                mon_runs++;
                if (ck_run != 4) mon_badrun++;
            end
            ck_run = 0;
        end
        if (busy_a && !valid_a && btn_a !== btn_prev_a) mon_btnchg++;
        btn_prev_a = btn_a;
    end

    logic [15:0] model_prev_a = '0;

    task automatic check_model_a(input logic [7:0] p0, input logic [7:0] p1, input string tag);
        logic [15:0] expv;
        expv = {p1, p0};
        check({tag, "_buttons"},  {16'h0, btn_a}, {16'h0, expv});
        check({tag, "_pressed"},  {16'h0, prs_a}, {16'h0, expv & ~model_prev_a});
        check({tag, "_released"}, {16'h0, rel_a}, {16'h0, ~expv & model_prev_a});
        model_prev_a = expv;
    endtask

    // Called at a negedge; returns at the negedge where o_valid is high.
    task automatic frame_a(input logic [7:0] p0, input logic [7:0] p1, output int unsigned lat);
        bit seen;
        int unsigned t_start;
        pat_a[0] = p0;
        pat_a[1] = p1;
        req_a = 1'b1;
        t_start = cyc + 1;
        @(negedge clk);
        req_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (valid_a) seen = 1'b1;
            else @(negedge clk);
        end
        check("a_valid_seen", {31'h0, seen}, 32'd1);
        lat = cyc - t_start;
    endtask

    // ---------------- instance B: CPP=4, 8 bits, POLL_PERIOD=100 ----------------
    logic        rst_b = 1'b0, req_b = 1'b0;
    logic        busy_b, valid_b, latch_b, clock_b;
    logic [15:0] btn_b, prs_b, rel_b;
    logic [1:0]  data_b;
    assign data_b = 2'b11;

    pad_poller #(.CYCLES_PER_PULSE(4), .NUM_PADS(2), .NUM_BITS(8), .POLL_PERIOD(100)) u_b (
        .clk(clk), .i_rst_n(rst_b), .i_read_buttons(req_b), .o_busy(busy_b), .o_valid(valid_b),
        .o_buttons(btn_b), .o_pressed(prs_b), .o_released(rel_b), .i_controller_data(data_b),
        .o_controller_latch(latch_b), .o_controller_clock(clock_b));

    int unsigned vb_q[$];
    always @(negedge clk) if (valid_b) vb_q.push_back(cyc);

    // ---------------- instance C: CPP=4, 2 pads, 16 bits, manual ----------------
    logic        rst_c = 1'b0, req_c = 1'b0;
    logic        busy_c, valid_c, latch_c, clock_c;
    logic [31:0] btn_c, prs_c, rel_c;
    logic [1:0]  data_c;

    pad_poller #(.CYCLES_PER_PULSE(4), .NUM_PADS(2), .NUM_BITS(16), .POLL_PERIOD(0)) u_c (
        .clk(clk), .i_rst_n(rst_c), .i_read_buttons(req_c), .o_busy(busy_c), .o_valid(valid_c),
        .o_buttons(btn_c), .o_pressed(prs_c), .o_released(rel_c), .i_controller_data(data_c),
        .o_controller_latch(latch_c), .o_controller_clock(clock_c));

    logic [15:0] pat_c [2];
    logic [15:0] held_c [2];
    int unsigned idx_c = 16;
    logic        lprev_c = 1'b0, cprev_c = 1'b1;
    always @(negedge clk) begin
        if (latch_c && !lprev_c) begin
            idx_c = 0;
            held_c = pat_c;
        end else if (clock_c && !cprev_c && !latch_c) begin
            idx_c++;
        end
        lprev_c = latch_c;
        cprev_c = clock_c;
        for (int p = 0; p < 2; p++)
            data_c[p] = (idx_c < 16) ? ~held_c[p][4'(15 - idx_c)] : 1'b1;
    end

    task automatic frame_c(input logic [15:0] p0, input logic [15:0] p1, output int unsigned lat);
        bit seen;
        int unsigned t_start;
        pat_c[0] = p0;
        pat_c[1] = p1;
        req_c = 1'b1;
        t_start = cyc + 1;
        @(negedge clk);
        req_c = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (valid_c) seen = 1'b1;
            else @(negedge clk);
        end
        check("c_valid_seen", {31'h0, seen}, 32'd1);
        lat = cyc - t_start;
    endtask

    typedef struct {
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [15:0] btn;
        logic [15:0] prs;
        logic [15:0] rel;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [4];
        int unsigned lat, t0, t1, tm, rb;
        int unsigned s_latch, s_busy, s_valid, s_idle, s_runs, s_bad;
        logic [7:0]  r0, r1;

        vecs[0] = '{8'h90, 8'h00, 16'h0090, 16'h0090, 16'h0000};
        vecs[1] = '{8'h81, 8'h00, 16'h0081, 16'h0001, 16'h0010};
        vecs[2] = '{8'h00, 8'hFF, 16'hFF00, 16'hFF00, 16'h0081};
        vecs[3] = '{8'hA5, 8'h3C, 16'h3CA5, 16'h00A5, 16'hC300};

        pat_a[0] = '0; pat_a[1] = '0;
        pat_c[0] = '0; pat_c[1] = '0;

        repeat (3) @(negedge clk);
        check("rst_latch",    {31'h0, latch_a}, 32'd0);
        check("rst_clock",    {31'h0, clock_a}, 32'd1);
        check("rst_busy",     {31'h0, busy_a},  32'd0);
        check("rst_valid",    {31'h0, valid_a}, 32'd0);
        check("rst_buttons",  {16'h0, btn_a},   32'd0);
        check("rst_pressed",  {16'h0, prs_a},   32'd0);
        check("rst_released", {16'h0, rel_a},   32'd0);
        rst_a = 1'b1;
        rst_c = 1'b1;
        repeat (2) @(negedge clk);

        // Table frames with full waveform checks.
        for (int i = 0; i < 4; i++) begin
            s_latch = mon_latch; s_busy = mon_busy; s_valid = mon_valid;
            s_idle = mon_idlebad; s_runs = mon_runs; s_bad = mon_badrun;
            frame_a(vecs[i].p0, vecs[i].p1, lat);
            check("tbl_latency",  lat, 32'd64);
            check("tbl_buttons",  {16'h0, btn_a}, {16'h0, vecs[i].btn});
            check("tbl_pressed",  {16'h0, prs_a}, {16'h0, vecs[i].prs});
            check("tbl_released", {16'h0, rel_a}, {16'h0, vecs[i].rel});
            @(negedge clk);
            check("tbl_busy_low",    {31'h0, busy_a},  32'd0);
            check("tbl_valid_low",   {31'h0, valid_a}, 32'd0);
            check("tbl_latch_high",  mon_latch - s_latch,  32'd4);
            check("tbl_busy_cycles", mon_busy - s_busy,    32'd65);
            check("tbl_valid_width", mon_valid - s_valid,  32'd1);
            check("tbl_clk_pulses",  mon_runs - s_runs,    32'd7);
            check("tbl_clk_width",   mon_badrun - s_bad,   32'd0);
            check("tbl_clk_idle",    mon_idlebad - s_idle, 32'd0);
        end
        model_prev_a = vecs[3].btn;

        // Requests while busy are dropped; next start is accepted right after valid falls.
        s_valid = mon_valid;
        pat_a[0] = 8'h42; pat_a[1] = 8'h18;
        req_a = 1'b1; t0 = cyc + 1;
        @(negedge clk); req_a = 1'b0;
        wait_cyc(t0 + 9);
        req_a = 1'b1; @(negedge clk); req_a = 1'b0;
        wait_cyc(t0 + 63);
        req_a = 1'b1; @(negedge clk); req_a = 1'b0;
        check("busy_seq_valid1", {31'h0, valid_a}, 32'd1);
        check_model_a(8'h42, 8'h18, "busy_seq1");
        wait_cyc(t0 + 65);
        check("busy_seq_idle", {31'h0, busy_a}, 32'd0);
        req_a = 1'b1; t1 = cyc + 1;
        @(negedge clk); req_a = 1'b0;
        wait_cyc(t1 + 63);
        check("busy_seq_one_valid", mon_valid - s_valid, 32'd1);
        @(negedge clk);
        check("busy_seq_valid2", {31'h0, valid_a}, 32'd1);
        check("busy_seq_t1", t1 - t0, 32'd66);
        check_model_a(8'h42, 8'h18, "busy_seq2");
        @(negedge clk);
        check("busy_seq_two_valid", mon_valid - s_valid, 32'd2);

        // Randomized frames against the reference model.
        s_bad = mon_btnchg;
        for (int i = 0; i < 12; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            frame_a(r0, r1, lat);
            check("rnd_latency", lat, 32'd64);
            check_model_a(r0, r1, "rnd");
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        end
        check("rnd_buttons_stable", mon_btnchg - s_bad, 32'd0);

        // 16-bit instance: full frame, reset during bit 5, full frame again.
        frame_c(16'hB00F, 16'h1234, lat);
        check("c1_latency",  lat, 32'd128);
        check("c1_buttons",  btn_c, 32'h1234B00F);
        check("c1_pressed",  prs_c, 32'h1234B00F);
        check("c1_released", rel_c, 32'h0);
        repeat (2) @(negedge clk);
        pat_c[0] = 16'hFFFF; pat_c[1] = 16'h0001;
        req_c = 1'b1; t0 = cyc + 1;
        @(negedge clk); req_c = 1'b0;
        wait_cyc(t0 + 43);
        check("c_mid_busy", {31'h0, busy_c}, 32'd1);
        rst_c = 1'b0;
        #1;
        check("c_rst_latch",   {31'h0, latch_c}, 32'd0);
        check("c_rst_clock",   {31'h0, clock_c}, 32'd1);
        check("c_rst_busy",    {31'h0, busy_c},  32'd0);
        check("c_rst_valid",   {31'h0, valid_c}, 32'd0);
        check("c_rst_buttons", btn_c, 32'h0);
        check("c_rst_pressed", prs_c, 32'h0);
        repeat (2) @(negedge clk);
        rst_c = 1'b1;
        @(negedge clk);
        frame_c(16'h8001, 16'h7FFE, lat);
        check("c3_latency",  lat, 32'd128);
        check("c3_buttons",  btn_c, 32'h7FFE8001);
        check("c3_pressed",  prs_c, 32'h7FFE8001);
        check("c3_released", rel_c, 32'h0);

        // Auto-poll: manual start at counter 50 restarts the period; a manual
        // request coinciding with an auto tick gives a single frame.
        @(negedge clk);
        rst_b = 1'b1; rb = cyc;
        wait_cyc(rb + 50);
        req_b = 1'b1; tm = cyc + 1;
        @(negedge clk); req_b = 1'b0;
        wait_cyc(tm + 399);
        req_b = 1'b1; @(negedge clk); req_b = 1'b0;
        wait_cyc(tm + 600);
        check("poll_count", vb_q.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            check("poll_valid_at", (i < vb_q.size()) ? vb_q[i] - tm : 32'hFFFF_FFFF, 32'(64 + 100 * i));
        check("poll_buttons", {16'h0, btn_b}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
